// File: rtl/place_flip_engine.sv
// Places a piece for the side to move, then walks the 8 directions one cell per cycle,
// flipping every bracketed opponent run. Reports legality, flip count and the new board.
module place_flip_engine #(
  parameter int BOARD_DIM = 8,
  parameter int CELL_W    = 3,
  parameter int BOARD_W   = BOARD_DIM*BOARD_DIM*CELL_W,
  parameter int IDX_W     = $clog2(BOARD_DIM*BOARD_DIM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BOARD_W-1:0] curr_board,
  input  logic [IDX_W-1:0]   index,
  input  logic               player_black,
  output logic               busy,
  output logic               done,
  output logic               legal,
  output logic [IDX_W:0]     flip_count,
  output logic [BOARD_W-1:0] result_board
);
  // Handshake: start is taken only in IDLE; busy stays high from that edge until done,
  // a single-cycle pulse carrying legal/flip_count/result_board. A start in the done
  // cycle is accepted.
  localparam int CELLS = BOARD_DIM*BOARD_DIM;
  localparam int RC_W  = $clog2(BOARD_DIM) + 1;
  localparam logic [RC_W-1:0]  DIM_RC  = RC_W'(BOARD_DIM);
  localparam logic [IDX_W:0]   CELLS_C = (IDX_W+1)'(CELLS);
  localparam logic [IDX_W:0]   ONE     = (IDX_W+1)'(1);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, FLIP} state_t;
  state_t state;

  logic [BOARD_W-1:0] cap_board, work_board, board_nxt, fin_board;
  logic [IDX_W-1:0]   idx_q;
  logic               blk_q;
  logic [RC_W-1:0]    tgt_r, tgt_c, pos_r, pos_c, fr, fc;
  logic [RC_W-1:0]    nxt_r, nxt_c, f1_r, f1_c, fn_r, fn_c;
  logic [2:0]         dir;
  logic [IDX_W:0]     run_len, flip_left, cnt, cnt_nxt;
  logic [CELL_W-1:0]  own_code, opp_code, nxt_cell;
  logic               off_board, tgt_occ, dir_end, to_flip;

  // Deltas are encoded 2'b01 = +1, 2'b11 = -1, 2'b00 = hold; rows grow downwards.
  function automatic logic [RC_W-1:0] step(input logic [RC_W-1:0] v, input logic [1:0] d);
    case (d)
      2'b01:   step = v + RC_W'(1);
      2'b11:   step = v - RC_W'(1);
      default: step = v;
    endcase
  endfunction

  function automatic logic [1:0] row_d(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: row_d = 2'b11;
      3'd3, 3'd4, 3'd5: row_d = 2'b01;
      default:          row_d = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] col_d(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: col_d = 2'b01;
      3'd5, 3'd6, 3'd7: col_d = 2'b11;
      default:          col_d = 2'b00;
    endcase
  endfunction

  function automatic int addr(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c);
    addr = BOARD_DIM*int'(r) + int'(c);
  endfunction

  always_comb begin
    own_code = {1'b1, {(CELL_W-2){1'b1}}, blk_q};
    opp_code = {1'b1, {(CELL_W-2){1'b1}}, ~blk_q};
    nxt_r = step(pos_r, row_d(dir));
    nxt_c = step(pos_c, col_d(dir));
    f1_r  = step(tgt_r, row_d(dir));
    f1_c  = step(tgt_c, col_d(dir));
    fn_r  = step(fr, row_d(dir));
    fn_c  = step(fc, col_d(dir));
    // Stepping below 0 wraps to a large value, so one unsigned compare catches both edges.
    off_board = (nxt_r >= DIM_RC) || (nxt_c >= DIM_RC);
    nxt_cell = '0;
    if (!off_board) nxt_cell = work_board[addr(nxt_r, nxt_c)*CELL_W +: CELL_W];
    tgt_occ = 1'b0;
    if ({1'b0, idx_q} < CELLS_C) tgt_occ = cap_board[idx_q*CELL_W + (CELL_W-1)];
    cnt_nxt = cnt;
    if (state == FLIP && flip_left == ONE) cnt_nxt = cnt + run_len;
    board_nxt = work_board;
    if (state == FLIP) board_nxt[addr(fr, fc)*CELL_W +: CELL_W] = own_code;
    fin_board = board_nxt;
    fin_board[idx_q*CELL_W +: CELL_W] = own_code;
    dir_end = 1'b0;
    to_flip = 1'b0;
    if (state == SCAN) begin
      if (!off_board && nxt_cell == opp_code) dir_end = 1'b0;
      else if (!off_board && nxt_cell == own_code && run_len != '0) to_flip = 1'b1;
      else dir_end = 1'b1;
    end else if (state == FLIP && flip_left == ONE) begin
      dir_end = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      legal        <= 1'b0;
      flip_count   <= '0;
      result_board <= '0;
      cap_board    <= '0;
      work_board   <= '0;
      idx_q        <= '0;
      blk_q        <= 1'b0;
      tgt_r        <= '0;
      tgt_c        <= '0;
      pos_r        <= '0;
      pos_c        <= '0;
      fr           <= '0;
      fc           <= '0;
      dir          <= '0;
      run_len      <= '0;
      flip_left    <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cap_board  <= curr_board;
          work_board <= curr_board;
          idx_q      <= index;
          blk_q      <= player_black;
          tgt_r      <= RC_W'(int'(index) / BOARD_DIM);
          tgt_c      <= RC_W'(int'(index) % BOARD_DIM);
          busy       <= 1'b1;
          state      <= CHECK;
        end
        CHECK: begin
          if (tgt_occ || {1'b0, idx_q} >= CELLS_C) begin
            legal        <= 1'b0;
            flip_count   <= '0;
            result_board <= cap_board;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            dir     <= '0;
            run_len <= '0;
            cnt     <= '0;
            pos_r   <= tgt_r;
            pos_c   <= tgt_c;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (to_flip) begin
            fr        <= f1_r;
            fc        <= f1_c;
            flip_left <= run_len;
            state     <= FLIP;
          end else if (!dir_end) begin
            run_len <= run_len + ONE;
            pos_r   <= nxt_r;
            pos_c   <= nxt_c;
          end
        end
        FLIP: begin
          work_board <= board_nxt;
          cnt        <= cnt_nxt;
          flip_left  <= flip_left - ONE;
          fr         <= fn_r;
          fc         <= fn_c;
        end
        default: state <= IDLE;
      endcase
      if (dir_end) begin
        run_len <= '0;
        pos_r   <= tgt_r;
        pos_c   <= tgt_c;
        if (dir == 3'd7) begin
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
          flip_count <= cnt_nxt;
          if (cnt_nxt != '0) begin
            legal        <= 1'b1;
            result_board <= fin_board;
          end else begin
            legal        <= 1'b0;
            result_board <= cap_board;
          end
        end else begin
          dir   <= dir + 3'd1;
          state <= SCAN;
        end
      end
    end
  end
endmodule

// File: tb/tb_place_flip_engine.sv
// Bench for place_flip_engine: three instances (8x8, 4x4, 5x5) checked against a
// reference move model through an expected-result queue.
module tb_place_flip_engine;
  typedef struct packed {
    logic         legal;
    logic [6:0]   cnt;
    logic [191:0] board;
    logic [15:0]  lat;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic start8, blk8, busy8, done8, legal8;
  logic [191:0] board8, res8;
  logic [5:0] idx8;
  logic [6:0] cnt8;
  logic start4, blk4, busy4, done4, legal4;
  logic [47:0] board4, res4;
  logic [3:0] idx4;
  logic [4:0] cnt4;
  logic start5, blk5, busy5, done5, legal5;
  logic [74:0] board5, res5;
  logic [4:0] idx5;
  logic [5:0] cnt5;

  place_flip_engine #(.BOARD_DIM(8)) u8 (.clk(clk), .reset(reset), .start(start8),
    .curr_board(board8), .index(idx8), .player_black(blk8), .busy(busy8), .done(done8),
    .legal(legal8), .flip_count(cnt8), .result_board(res8));
  place_flip_engine #(.BOARD_DIM(4)) u4 (.clk(clk), .reset(reset), .start(start4),
    .curr_board(board4), .index(idx4), .player_black(blk4), .busy(busy4), .done(done4),
    .legal(legal4), .flip_count(cnt4), .result_board(res4));
  place_flip_engine #(.BOARD_DIM(5)) u5 (.clk(clk), .reset(reset), .start(start5),
    .curr_board(board5), .index(idx5), .player_black(blk5), .busy(busy5), .done(done5),
    .legal(legal5), .flip_count(cnt5), .result_board(res5));

  res_t exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int sel = 8;

  logic obs_busy, obs_done, obs_legal;
  logic [6:0] obs_cnt;
  logic [191:0] obs_board;
  always_comb begin
    obs_busy = busy8; obs_done = done8; obs_legal = legal8; obs_cnt = cnt8; obs_board = res8;
    if (sel == 4) begin
      obs_busy = busy4; obs_done = done4; obs_legal = legal4;
      obs_cnt = 7'(cnt4); obs_board = 192'(res4);
    end else if (sel == 5) begin
      obs_busy = busy5; obs_done = done5; obs_legal = legal5;
      obs_cnt = 7'(cnt5); obs_board = 192'(res5);
    end
  end

  function automatic string fmt(input res_t r);
    return $sformatf("legal=%0b cnt=%0d lat=%0d board=%h", r.legal, r.cnt, r.lat, r.board);
  endfunction

  // Reference move: lat counts the CHECK cycle plus one cycle per scanned cell and per flip.
  function automatic res_t model(input int dim, input logic [191:0] brd, input int idx, input logic blk);
    res_t r;
    logic [2:0] own, opp, v;
    logic [191:0] b;
    int dr[8], dc[8];
    int tot, n, rr, cc, row, col;
    dr = '{-1, -1, 0, 1, 1, 1, 0, -1};
    dc = '{0, 1, 1, 1, 0, -1, -1, -1};
    own = {2'b11, blk};
    opp = {2'b11, ~blk};
    r = '0;
    r.board = brd;
    r.lat = 16'd1;
    if (idx >= dim*dim || brd[idx*3+2]) return r;
    row = idx / dim; col = idx % dim; b = brd; tot = 0;
    for (int d = 0; d < 8; d++) begin
      n = 0; rr = row + dr[d]; cc = col + dc[d];
      for (int s = 0; s < 16; s++) begin
        r.lat++;
        if (rr < 0 || rr >= dim || cc < 0 || cc >= dim) break;
        v = brd[(rr*dim+cc)*3 +: 3];
        if (v == opp) begin
          n++; rr += dr[d]; cc += dc[d];
        end else begin
          if (v == own && n > 0) begin
            for (int k = 1; k <= n; k++) b[((row+k*dr[d])*dim + col+k*dc[d])*3 +: 3] = own;
            r.lat += 16'(n);
            tot += n;
          end
          break;
        end
      end
    end
    if (tot > 0) begin
      b[idx*3 +: 3] = own;
      r.legal = 1'b1; r.cnt = 7'(tot); r.board = b;
    end
    return r;
  endfunction

  function automatic logic [191:0] opening(input int dim);
    logic [191:0] b;
    int m;
    b = '0; m = dim / 2;
    b[((m-1)*dim + m-1)*3 +: 3] = 3'b110;
    b[((m-1)*dim + m)*3 +: 3]   = 3'b111;
    b[(m*dim + m-1)*3 +: 3]     = 3'b111;
    b[(m*dim + m)*3 +: 3]       = 3'b110;
    return b;
  endfunction

  function automatic logic [191:0] rand_board(input int dim);
    logic [191:0] b;
    b = '0;
    for (int i = 0; i < dim*dim; i++) begin
      int r = $urandom_range(0, 9);
      if (r >= 3) b[i*3 +: 3] = (r >= 6) ? 3'b111 : 3'b110;
    end
    return b;
  endfunction

  task automatic set_in(input logic st, input logic [191:0] b, input int idx, input logic blk);
    case (sel)
      4: begin start4 = st; board4 = b[47:0]; idx4 = 4'(idx); blk4 = blk; end
      5: begin start5 = st; board5 = b[74:0]; idx5 = 5'(idx); blk5 = blk; end
      default: begin start8 = st; board8 = b; idx8 = 6'(idx); blk8 = blk; end
    endcase
  endtask

  // Issues one move and waits (bounded) for done; a timeout leaves lat at all-ones.
  task automatic drive(input logic [191:0] b, input int idx, input logic blk, output res_t got);
    @(negedge clk); set_in(1'b1, b, idx, blk);
    @(posedge clk); #1; set_in(1'b0, b, idx, blk);
    got = '0;
    got.lat = '1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (obs_done) begin
        got = {obs_legal, obs_cnt, obs_board, 16'(cyc)};
        break;
      end
    end
  endtask

  task automatic test_reset();
    int dims[3] = '{8, 4, 5};
    for (int i = 0; i < 3; i++) begin
      sel = dims[i]; #1;
      n_vec++;
      if ({obs_busy, obs_done, obs_legal, obs_cnt, obs_board} !== '0) begin
        n_fail++;
        $display("FAIL reset_dim%0d: busy=%b done=%b legal=%b cnt=%0d board=%h, want all zero",
                 sel, obs_busy, obs_done, obs_legal, obs_cnt, obs_board);
      end
    end
  endtask

  task automatic test_opening();
    int t_dim[6] = '{8, 8, 8, 8, 5, 4};
    int t_idx[6] = '{19, 20, 27, 0, 30, 1};
    bit t_blk[6] = '{1, 0, 1, 1, 1, 1};
    bit t_leg[6] = '{1, 1, 0, 0, 0, 1};
    int t_cnt[6] = '{1, 1, 0, 0, 0, 1};
    int t_lat[6] = '{11, 11, 1, 9, 1, 11};
    res_t e, got;
    logic [191:0] b;
    for (int i = 0; i < 6; i++) begin
      sel = t_dim[i];
      b = opening(sel);
      exp_q.push_back(model(sel, b, t_idx[i], t_blk[i]));
      drive(b, t_idx[i], t_blk[i], got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL opening_%0d: got %s, want %s", i, fmt(got), fmt(e));
      end
      n_vec++;
      if ({got.legal, got.cnt, got.lat} !== {t_leg[i], 7'(t_cnt[i]), 16'(t_lat[i])}) begin
        n_fail++;
        $display("FAIL opening_fixed_%0d: got legal=%0b cnt=%0d lat=%0d, want legal=%0b cnt=%0d lat=%0d",
                 i, got.legal, got.cnt, got.lat, t_leg[i], t_cnt[i], t_lat[i]);
      end
    end
  endtask

  task automatic test_custom();
    logic [191:0] b[2];
    int want_cnt[2] = '{4, 0};
    res_t e, got;
    b[0] = '0;
    b[0][19*3 +: 3] = 3'b110; b[0][11*3 +: 3] = 3'b110; b[0][3*3 +: 3]  = 3'b111;
    b[0][28*3 +: 3] = 3'b110; b[0][29*3 +: 3] = 3'b111;
    b[0][34*3 +: 3] = 3'b110; b[0][41*3 +: 3] = 3'b111;
    b[1] = '0;
    for (int r = 4; r < 8; r++) begin
      b[0][(r*8+3)*3 +: 3] = 3'b110;
      b[1][(r*8+3)*3 +: 3] = 3'b110;
    end
    sel = 8;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(8, b[i], 27, 1'b1));
      drive(b[i], 27, 1'b1, got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e || got.cnt !== 7'(want_cnt[i])) begin
        n_fail++;
        $display("FAIL custom_%0d: got %s, want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_busy_start();
    res_t e, got;
    logic [191:0] b;
    int n_done;
    sel = 8; b = opening(8);
    exp_q.push_back(model(8, b, 19, 1'b1));
    got = '0; got.lat = '1; n_done = 0;
    @(negedge clk); set_in(1'b1, b, 19, 1'b1);
    @(posedge clk); #1; set_in(1'b0, b, 19, 1'b1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (obs_done) begin
        n_done++;
        if (n_done == 1) got = {obs_legal, obs_cnt, obs_board, 16'(cyc)};
      end
      set_in((cyc == 2 || cyc == 5), b, 20, 1'b0);
    end
    e = exp_q.pop_front();
    n_vec++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL busy_start_pulses: saw %0d done pulses, want 1", n_done);
    end
    n_vec++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL busy_start_result: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    res_t e, ga, gb;
    logic [191:0] b;
    int phase, c;
    sel = 8; b = opening(8);
    exp_q.push_back(model(8, b, 19, 1'b1));
    exp_q.push_back(model(8, b, 20, 1'b0));
    ga = '0; ga.lat = '1; gb = ga; phase = 0; c = 0;
    @(negedge clk); set_in(1'b1, b, 19, 1'b1);
    @(posedge clk); #1; set_in(1'b1, b, 20, 1'b0);
    for (int cyc = 0; cyc < 200 && phase < 3; cyc++) begin
      @(posedge clk); #1; c++;
      if (phase == 1) begin
        n_vec++;
        if (obs_done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_done_width: done=%b one cycle after pulse, want 0", obs_done);
        end
        set_in(1'b0, b, 20, 1'b0);
        phase = 2; c = 0;
      end else if (obs_done) begin
        if (phase == 0) begin ga = {obs_legal, obs_cnt, obs_board, 16'(c)}; phase = 1; end
        else begin gb = {obs_legal, obs_cnt, obs_board, 16'(c)}; phase = 3; end
      end
    end
    set_in(1'b0, b, 20, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (ga !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got %s, want %s", fmt(ga), fmt(e));
    end
    e = exp_q.pop_front();
    n_vec++;
    if (gb !== e) begin
      n_fail++;
      $display("FAIL b2b_second: got %s, want %s", fmt(gb), fmt(e));
    end
  endtask

  task automatic test_reset_mid();
    res_t e, got;
    logic [191:0] b;
    sel = 8; b = opening(8);
    @(negedge clk); set_in(1'b1, b, 19, 1'b1);
    @(posedge clk); #1; set_in(1'b0, b, 19, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({obs_busy, obs_done, obs_legal, obs_cnt, obs_board} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b legal=%b cnt=%0d board=%h, want all zero",
               obs_busy, obs_done, obs_legal, obs_cnt, obs_board);
    end
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(model(8, b, 19, 1'b1));
    drive(b, 19, 1'b1, got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_random();
    res_t e, got;
    logic [191:0] b;
    int idx;
    logic blk;
    for (int i = 0; i < 24; i++) begin
      sel = (i % 3 == 0) ? 8 : ((i % 3 == 1) ? 4 : 5);
      b = rand_board(sel);
      blk = 1'($urandom_range(0, 1));
      if (sel == 5) idx = $urandom_range(0, 31);
      else begin
        idx = $urandom_range(0, sel*sel-1);
        for (int t = 0; t < 20 && b[idx*3+2]; t++) idx = $urandom_range(0, sel*sel-1);
      end
      exp_q.push_back(model(sel, b, idx, blk));
      drive(b, idx, blk, got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL random_%0d dim=%0d idx=%0d: got %s, want %s", i, sel, idx, fmt(got), fmt(e));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start8 = 1'b0; board8 = '0; idx8 = '0; blk8 = 1'b0;
    start4 = 1'b0; board4 = '0; idx4 = '0; blk4 = 1'b0;
    start5 = 1'b0; board5 = '0; idx5 = '0; blk5 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_opening();
    test_custom();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
